// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation is in flight at a time: accept (IDLE) -> execute (EXEC) -> respond (RESP).
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*SEL_W-1:0]  req_sel,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   output logic [1:0]          rsp_valid,
   input  logic [1:0]          rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_zero,
   output logic [SEL_W-1:0]    alu_sel,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic [DATA_W-1:0]   alu_sout,
   input  logic                alu_zero,
   output logic                busy,
   output logic [15:0]         op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_next;

   logic              rr_ptr;
   logic              owner;
   logic              winner;
   logic              accept;
   logic              rsp_done;
   logic [SEL_W-1:0]  sel_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;

   // Arbitration and next-state; rr_ptr only matters when both requesters contend.
   always_comb begin
      winner     = (&req_valid) ? rr_ptr : req_valid[1];
      accept     = (state == IDLE) && (|req_valid);
      rsp_done   = (state == RESP) && rsp_ready[owner];
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even before the first reset edge.
   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      busy      = 1'b0;
      alu_sel   = '0;
      alu_a     = '0;
      alu_b     = '0;
      if (rst_n) begin
         busy = (state != IDLE);
         if (accept)
            req_ready = {winner, ~winner};
         if (state == RESP)
            rsp_valid = {owner, ~owner};
         if (state == EXEC) begin
            alu_sel = sel_q;
            alu_a   = a_q;
            alu_b   = b_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Operand capture, result capture and handshake counting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr   <= 1'b0;
         owner    <= 1'b0;
         sel_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         op_count <= 16'd0;
      end else begin
         if (accept) begin
            owner  <= winner;
            rr_ptr <= ~winner;
            sel_q  <= winner ? req_sel[2*SEL_W-1:SEL_W]   : req_sel[SEL_W-1:0];
            a_q    <= winner ? req_a[2*DATA_W-1:DATA_W]   : req_a[DATA_W-1:0];
            b_q    <= winner ? req_b[2*DATA_W-1:DATA_W]   : req_b[DATA_W-1:0];
         end
         if (state == EXEC) begin
            rsp_data <= alu_sout;
            rsp_zero <= alu_zero;
         end
         if (rsp_done)
            op_count <= op_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU on the alu_* ports, a transaction-level
// reference model, directed scenarios and a randomized soak with occasional resets.
module tb_alu_arbiter;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 6;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*SEL_W-1:0]  req_sel;
   logic [2*DATA_W-1:0] req_a;
   logic [2*DATA_W-1:0] req_b;
   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready;
   logic [DATA_W-1:0]   rsp_data;
   logic                rsp_zero;
   logic [SEL_W-1:0]    alu_sel;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [DATA_W-1:0]   alu_sout;
   logic                alu_zero;
   logic                busy;
   logic [15:0]         op_count;

   logic [SEL_W-1:0]  sel0, sel1;
   logic [DATA_W-1:0] a0, a1, b0, b1;

   assign req_sel = {sel1, sel0};
   assign req_a   = {a1, a0};
   assign req_b   = {b1, b0};

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sout(alu_sout), .alu_zero(alu_zero),
      .busy(busy), .op_count(op_count)
   );

   function automatic logic [DATA_W-1:0] alu_ref(input logic [SEL_W-1:0] s,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      case (s)
         6'b100000: return a + b;
         6'b100010: return a - b;
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b100110: return a ^ b;
         6'b100111: return ~(a | b);
         6'b101010: return {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default:   return '0;
      endcase
   endfunction

   always_comb begin
      alu_sout = alu_ref(alu_sel, alu_a, alu_b);
      alu_zero = (alu_sout == '0);
   end

   int checks = 0;
   int errors = 0;

   // Reference model: age of the in-flight op (-1 none, 1 executing, 2 responding).
   int                age     = -1;
   bit                turn    = 1'b0;
   bit                m_owner = 1'b0;
   logic [SEL_W-1:0]  m_sel   = '0;
   logic [DATA_W-1:0] m_a     = '0;
   logic [DATA_W-1:0] m_b     = '0;
   logic [DATA_W-1:0] m_data  = '0;
   bit                m_zero  = 1'b0;
   logic [15:0]       m_count = 16'd0;

   logic [1:0]        obs_ready, obs_rspv;
   logic [DATA_W-1:0] obs_data;
   logic              obs_zero;
   logic [15:0]       obs_count;

   logic [1:0]        grants[$];
   logic [DATA_W-1:0] results[$];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rr, input logic rst);
      logic [1:0] exp_ready;
      bit         w;
      req_valid = v;
      rsp_ready = rr;
      rst_n     = rst;
      @(negedge clk);
      if (!rst) begin
         checkOutput("rst_req_ready", req_ready, 2'b00);
         checkOutput("rst_rsp_valid", rsp_valid, 2'b00);
         checkOutput("rst_busy", busy, 1'b0);
         checkOutput("rst_alu_sel", alu_sel, '0);
         checkOutput("rst_alu_a", alu_a, '0);
         checkOutput("rst_alu_b", alu_b, '0);
      end else begin
         exp_ready = 2'b00;
         if (age < 0 && v != 2'b00) begin
            w = (v == 2'b11) ? turn : v[1];
            exp_ready = w ? 2'b10 : 2'b01;
         end
         checkOutput("req_ready", req_ready, exp_ready);
         checkOutput("busy", busy, (age >= 0));
         checkOutput("alu_sel", alu_sel, (age == 1) ? m_sel : '0);
         checkOutput("alu_a", alu_a, (age == 1) ? m_a : '0);
         checkOutput("alu_b", alu_b, (age == 1) ? m_b : '0);
         checkOutput("rsp_valid", rsp_valid, (age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
         checkOutput("rsp_data", rsp_data, m_data);
         checkOutput("rsp_zero", rsp_zero, m_zero);
         checkOutput("op_count", op_count, m_count);
      end
      obs_ready = req_ready;
      obs_rspv  = rsp_valid;
      obs_data  = rsp_data;
      obs_zero  = rsp_zero;
      obs_count = op_count;
      @(posedge clk);
      if (!rst) begin
         age = -1; turn = 1'b0; m_data = '0; m_zero = 1'b0; m_count = 16'd0;
      end else if (age < 0) begin
         if (v != 2'b00) begin
            w       = (v == 2'b11) ? turn : v[1];
            m_owner = w;
            m_sel   = w ? sel1 : sel0;
            m_a     = w ? a1 : a0;
            m_b     = w ? b1 : b0;
            turn    = ~w;
            age     = 1;
         end
      end else if (age == 1) begin
         m_data = alu_ref(m_sel, m_a, m_b);
         m_zero = (m_data == '0);
         age    = 2;
      end else if (rr[m_owner]) begin
         m_count = m_count + 16'd1;
         age     = -1;
      end
      #1;
   endtask

   logic [SEL_W-1:0] codes [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                   6'b100110, 6'b100111, 6'b101010, 6'b000000};

   initial begin
      sel0 = '0; sel1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
      req_valid = 2'b00; rsp_ready = 2'b00; rst_n = 1'b0;
      #1;

      applyStimulus(2'b00, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b1);
      checkOutput("reset_data", obs_data, 0);
      checkOutput("reset_count", obs_count, 0);

      // Single op from r0: 5 + 7
      sel0 = 6'b100000; a0 = 5; b0 = 7;
      applyStimulus(2'b01, 2'b00, 1'b1);
      checkOutput("single_ready", obs_ready, 2'b01);
      applyStimulus(2'b00, 2'b00, 1'b1);
      checkOutput("single_exec_rspv", obs_rspv, 2'b00);
      applyStimulus(2'b00, 2'b01, 1'b1);
      checkOutput("single_rspv", obs_rspv, 2'b01);
      checkOutput("single_data", obs_data, 12);
      checkOutput("single_zero", obs_zero, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b1);
      checkOutput("single_count", obs_count, 1);

      // Contention from a fresh reset: grants alternate starting with r0
      applyStimulus(2'b00, 2'b00, 1'b0);
      sel0 = 6'b100000; a0 = 1;     b0 = 1;
      sel1 = 6'b100101; a1 = 32'hF0; b1 = 32'h0F;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(2'b11, 2'b11, 1'b1);
         if (obs_ready != 2'b00) grants.push_back(obs_ready);
         if (obs_rspv != 2'b00) results.push_back(obs_data);
      end
      checkOutput("grant_count", grants.size(), 4);
      checkOutput("grant0", grants[0], 2'b01);
      checkOutput("grant1", grants[1], 2'b10);
      checkOutput("grant2", grants[2], 2'b01);
      checkOutput("grant3", grants[3], 2'b10);
      checkOutput("contend_data0", results[0], 2);
      checkOutput("contend_data1", results[1], 32'hFF);

      // Backpressure: r0 holds, non-owner ready and new requests are ignored
      sel0 = 6'b100110; a0 = 32'h1234; b0 = 32'h00FF;
      applyStimulus(2'b01, 2'b00, 1'b1);
      applyStimulus(2'b11, 2'b00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b11, 2'b10, 1'b1);
         checkOutput("bp_rspv", obs_rspv, 2'b01);
         checkOutput("bp_ready", obs_ready, 2'b00);
         checkOutput("bp_data", obs_data, 32'h12CB);
      end
      applyStimulus(2'b11, 2'b01, 1'b1);
      applyStimulus(2'b11, 2'b00, 1'b1);
      checkOutput("bp_next_grant", obs_ready, 2'b10);
      applyStimulus(2'b00, 2'b00, 1'b1);
      applyStimulus(2'b00, 2'b10, 1'b1);

      // Zero flag, set-less-than and sel=0
      sel0 = 6'b100010; a0 = 9; b0 = 9;
      applyStimulus(2'b01, 2'b00, 1'b1);
      applyStimulus(2'b00, 2'b00, 1'b1);
      applyStimulus(2'b00, 2'b01, 1'b1);
      checkOutput("sub_data", obs_data, 0);
      checkOutput("sub_zero", obs_zero, 1'b1);
      sel0 = 6'b101010; a0 = 3; b0 = 9;
      applyStimulus(2'b01, 2'b00, 1'b1);
      applyStimulus(2'b00, 2'b00, 1'b1);
      applyStimulus(2'b00, 2'b01, 1'b1);
      checkOutput("slt_data", obs_data, 1);
      checkOutput("slt_zero", obs_zero, 1'b0);
      sel1 = 6'b000000; a1 = 77; b1 = 3;
      applyStimulus(2'b10, 2'b00, 1'b1);
      applyStimulus(2'b00, 2'b00, 1'b1);
      applyStimulus(2'b00, 2'b10, 1'b1);
      checkOutput("sel0_data", obs_data, 0);
      checkOutput("sel0_zero", obs_zero, 1'b1);

      // Reset during EXEC aborts the op; r1 alone wins afterwards
      sel0 = 6'b100000; a0 = 5; b0 = 7;
      applyStimulus(2'b01, 2'b00, 1'b1);
      applyStimulus(2'b01, 2'b11, 1'b0);
      applyStimulus(2'b10, 2'b11, 1'b1);
      checkOutput("abort_rspv", obs_rspv, 2'b00);
      checkOutput("abort_count", obs_count, 0);
      checkOutput("abort_grant", obs_ready, 2'b10);
      applyStimulus(2'b00, 2'b11, 1'b1);
      applyStimulus(2'b00, 2'b11, 1'b1);
      checkOutput("abort_next_rspv", obs_rspv, 2'b10);

      // Randomized soak against the reference model
      for (int i = 0; i < 3000; i++) begin
         sel0 = codes[$urandom_range(0, 7)];
         sel1 = codes[$urandom_range(0, 7)];
         a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
         applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 199) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
